osnt_ipd_arbiter: RTL and testbench

packet-granular round-robin arbiter with per-input burst limit, merging two inter-packet-delay output streams onto one AXI4-Stream egress.

Interface
REQ-001 Parameter C_AXIS_DATA_WIDTH, default 512, tdata width of all streams.
REQ-002 Parameter C_AXIS_TUSER_WIDTH, default 128, tuser width of all streams.
REQ-003 Parameter C_BURST_WIDTH, default 8, width of burst-limit inputs.
REQ-004 axis_aclk  in  1  sole clock; all logic SHALL be synchronous to its rising edge.
REQ-005 axis_areset  in  1  reset, asynchronous assert, active-high.
REQ-006 s0_axis_tdata/tkeep/tuser/tvalid/tlast  in  DW/DW/8/TW/1/1  input stream 0; s0_axis_tready out 1.
REQ-007 s1_axis_* as REQ-006 for input stream 1.
REQ-008 m_axis_tdata/tkeep/tuser/tvalid/tlast  out  DW/DW/8/TW/1/1  egress stream; m_axis_tready in 1.
REQ-009 sw_rst  in  1  software reset of counters and arbitration state, level-sensitive.
REQ-010 arb_en  in  1  1 = grants permitted; 0 = no new grant issued.
REQ-011 burst_limit0, burst_limit1  in  C_BURST_WIDTH  maximum consecutive packets per grant; value 0 SHALL be treated as 1.
REQ-012 pkt_cnt0, pkt_cnt1  out  32  packets forwarded per input.
REQ-013 grant  out  2  one-hot current owner; 2'b00 when idle.

Function
REQ-014 FSM states: IDLE, PASS.
REQ-015 IDLE -> PASS when arb_en=1 and any s*_axis_tvalid=1; the chosen input SHALL be registered into grant at that edge.
REQ-016 Selection: if last owner L has tvalid and burst_cnt < effective burst_limitL, keep L; otherwise pick the other input if it has tvalid; otherwise L when tvalid.
REQ-017 On switching owner, burst_cnt SHALL reload to 0; on keeping owner, it SHALL not reset.
REQ-018 In PASS, m_axis_tdata/tkeep/tuser/tlast/tvalid SHALL combinationally mirror the granted input; granted s*_axis_tready SHALL equal m_axis_tready; the non-granted tready SHALL be 0.
REQ-019 In IDLE, m_axis_tvalid and both s*_axis_tready SHALL be 0 (one bubble cycle per arbitration).
REQ-020 PASS -> IDLE on the cycle m_axis_tvalid & m_axis_tready & m_axis_tlast; at that edge pkt_cnt of the owner and burst_cnt SHALL increment by 1 and grant SHALL go to 2'b00.
REQ-021 burst_cnt width SHALL be C_BURST_WIDTH+1 and SHALL saturate, never wrap.
REQ-022 pkt_cnt0/1 SHALL wrap 32'hFFFFFFFF -> 0.
REQ-023 A packet SHALL never be interleaved or truncated: grant changes only in IDLE.
REQ-024 arb_en deasserted in PASS SHALL not affect the current packet; the FSM stays in IDLE afterwards until arb_en=1.
REQ-025 burst_limit changes SHALL take effect at the next IDLE decision.
REQ-026 Simultaneous tvalid on both inputs with no history SHALL grant input 0.

Reset
REQ-027 axis_areset=1 SHALL immediately force: state IDLE, grant 0, m_axis_tvalid 0, s*_axis_tready 0, pkt_cnt0/1 0, burst_cnt 0, last owner = input 1 (so input 0 wins first).
REQ-028 sw_rst=1 SHALL clear pkt_cnt0/1 and burst_cnt on the next edge; in PASS the packet SHALL complete before the FSM honours sw_rst, and last owner SHALL return to input 1 at that point.
REQ-029 Reset mid-packet (axis_areset) SHALL drop the ownership; the next beat seen is treated as a fresh arbitration.

Verification
REQ-030 Both inputs continuously valid, 3-beat packets, burst_limit0=2, burst_limit1=1 -> egress order 0,0,1,0,0,1; pkt_cnt0=4, pkt_cnt1=2 after 6 packets.
REQ-031 burst_limit0=0, only input 0 valid -> every packet granted to 0, one idle cycle between packets, pkt_cnt0 increments per tlast.
REQ-032 m_axis_tready toggling 1/0 each cycle during 4-beat packet -> data beats unchanged and in order, s0_axis_tready tracks m_axis_tready, no beat from input 1.
REQ-033 arb_en cleared mid-packet -> packet completes with tlast, then m_axis_tvalid stays 0 while arb_en=0 despite pending tvalid.
REQ-034 pkt_cnt0 preloaded by forcing to 32'hFFFFFFFF, one more packet -> pkt_cnt0=0.
REQ-035 axis_areset pulsed mid-packet -> grant=0, m_axis_tvalid=0 within same cycle; after release, input 0 wins if both valid.

---
 rtl/osnt_ipd_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_osnt_ipd_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osnt_ipd_arbiter.sv
// osnt_ipd_arbiter
// Packet-granular round-robin arbiter that merges two inter-packet-delay
// AXI4-Stream sources onto one egress. Each input may hold ownership for up
// to burst_limitN consecutive packets, where a limit of 0 behaves as 1.
// Ownership only changes in IDLE, which costs one bubble cycle per packet.
// That guarantees a packet is never interleaved with, or truncated by,
// another one.
module osnt_ipd_arbiter #(
  parameter int C_AXIS_DATA_WIDTH  = 512,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_BURST_WIDTH      = 8
) (
  input  logic                            axis_aclk,
  input  logic                            axis_areset,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    s0_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s0_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s0_axis_tuser,
  input  logic                            s0_axis_tvalid,
  input  logic                            s0_axis_tlast,
  output logic                            s0_axis_tready,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    s1_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s1_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s1_axis_tuser,
  input  logic                            s1_axis_tvalid,
  input  logic                            s1_axis_tlast,
  output logic                            s1_axis_tready,

  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,

  input  logic                            sw_rst,
  input  logic                            arb_en,
  input  logic [C_BURST_WIDTH-1:0]        burst_limit0,
  input  logic [C_BURST_WIDTH-1:0]        burst_limit1,
  output logic [31:0]                     pkt_cnt0,
  output logic [31:0]                     pkt_cnt1,
  output logic [1:0]                      grant
);

  // One extra bit so that a counter sitting at the largest possible limit
  // still compares as "limit reached" instead of wrapping back below it.
  localparam int BCW = C_BURST_WIDTH + 1;
  localparam logic [BCW-1:0] BURST_ONE = {{C_BURST_WIDTH{1'b0}}, 1'b1};
  localparam logic [BCW-1:0] BURST_MAX = {BCW{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PASS = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_grant;
  logic [1:0]       w_grant_nxt;
  logic             r_last_owner;
  logic             w_last_owner_nxt;
  logic             r_has_hist;
  logic             w_has_hist_nxt;
  logic [BCW-1:0]   r_burst_cnt;
  logic [BCW-1:0]   w_burst_cnt_nxt;
  logic [31:0]      r_pkt_cnt0;
  logic [31:0]      w_pkt_cnt0_nxt;
  logic [31:0]      r_pkt_cnt1;
  logic [31:0]      w_pkt_cnt1_nxt;

  logic [BCW-1:0]   w_lim0;
  logic [BCW-1:0]   w_lim1;
  logic [BCW-1:0]   w_lim_last;
  logic             w_valid_last;
  logic             w_valid_other;
  logic             w_pick_vld;
  logic             w_pick;
  logic             w_switch;
  logic             w_eop;

  // Effective burst limits (0 acts as 1) and the view from the last owner.
  always_comb begin
    w_lim0        = (burst_limit0 == {C_BURST_WIDTH{1'b0}}) ? BURST_ONE : {1'b0, burst_limit0};
    w_lim1        = (burst_limit1 == {C_BURST_WIDTH{1'b0}}) ? BURST_ONE : {1'b0, burst_limit1};
    w_lim_last    = r_last_owner ? w_lim1 : w_lim0;
    w_valid_last  = r_last_owner ? s1_axis_tvalid : s0_axis_tvalid;
    w_valid_other = r_last_owner ? s0_axis_tvalid : s1_axis_tvalid;
  end

  // Pick the next owner: keep the last owner while under its burst limit,
  // otherwise hand over to the other input. With no history input 0 wins.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick     = r_last_owner;
    if (!r_has_hist) begin
      if (s0_axis_tvalid) begin
        w_pick_vld = 1'b1;
        w_pick     = 1'b0;
      end else if (s1_axis_tvalid) begin
        w_pick_vld = 1'b1;
        w_pick     = 1'b1;
      end else begin
        w_pick_vld = 1'b0;
      end
    end else if (w_valid_last && (r_burst_cnt < w_lim_last)) begin
      w_pick_vld = 1'b1;
      w_pick     = r_last_owner;
    end else if (w_valid_other) begin
      w_pick_vld = 1'b1;
      w_pick     = ~r_last_owner;
    end else if (w_valid_last) begin
      w_pick_vld = 1'b1;
      w_pick     = r_last_owner;
    end else begin
      w_pick_vld = 1'b0;
    end
    w_switch = (!r_has_hist) || (w_pick != r_last_owner);
  end

  // Egress mux: mirror the granted input while passing, otherwise idle.
  always_comb begin
    m_axis_tdata   = {C_AXIS_DATA_WIDTH{1'b0}};
    m_axis_tkeep   = {(C_AXIS_DATA_WIDTH/8){1'b0}};
    m_axis_tuser   = {C_AXIS_TUSER_WIDTH{1'b0}};
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    if ((r_state == ST_PASS) && (r_grant == 2'b01)) begin
      m_axis_tdata   = s0_axis_tdata;
      m_axis_tkeep   = s0_axis_tkeep;
      m_axis_tuser   = s0_axis_tuser;
      m_axis_tvalid  = s0_axis_tvalid;
      m_axis_tlast   = s0_axis_tlast;
      s0_axis_tready = m_axis_tready;
    end else if ((r_state == ST_PASS) && (r_grant == 2'b10)) begin
      m_axis_tdata   = s1_axis_tdata;
      m_axis_tkeep   = s1_axis_tkeep;
      m_axis_tuser   = s1_axis_tuser;
      m_axis_tvalid  = s1_axis_tvalid;
      m_axis_tlast   = s1_axis_tlast;
      s1_axis_tready = m_axis_tready;
    end else begin
      m_axis_tvalid  = 1'b0;
    end
  end

  // End of packet: last beat accepted by the egress while passing.
  always_comb begin
    w_eop = (r_state == ST_PASS) && m_axis_tvalid && m_axis_tready && m_axis_tlast;
  end

  // Next-state logic: grant in IDLE, release and count at end of packet.
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_owner_nxt = r_last_owner;
    w_has_hist_nxt   = r_has_hist;
    w_burst_cnt_nxt  = r_burst_cnt;
    w_pkt_cnt0_nxt   = r_pkt_cnt0;
    w_pkt_cnt1_nxt   = r_pkt_cnt1;
    case (r_state)
      ST_IDLE: begin
        if (sw_rst) begin
          w_last_owner_nxt = 1'b1;
          w_has_hist_nxt   = 1'b0;
        end else if (arb_en && w_pick_vld) begin
          w_state_nxt      = ST_PASS;
          w_grant_nxt      = w_pick ? 2'b10 : 2'b01;
          w_last_owner_nxt = w_pick;
          w_has_hist_nxt   = 1'b1;
          if (w_switch) begin
            w_burst_cnt_nxt = {BCW{1'b0}};
          end else begin
            w_burst_cnt_nxt = r_burst_cnt;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PASS: begin
        if (w_eop) begin
          w_state_nxt     = ST_IDLE;
          w_grant_nxt     = 2'b00;
          w_burst_cnt_nxt = (r_burst_cnt == BURST_MAX) ? r_burst_cnt : (r_burst_cnt + BURST_ONE);
          if (r_grant[1]) begin
            w_pkt_cnt1_nxt = r_pkt_cnt1 + 32'd1;
          end else begin
            w_pkt_cnt0_nxt = r_pkt_cnt0 + 32'd1;
          end
          if (sw_rst) begin
            w_last_owner_nxt = 1'b1;
            w_has_hist_nxt   = 1'b0;
          end else begin
            w_last_owner_nxt = r_last_owner;
          end
        end else begin
          w_state_nxt = ST_PASS;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 2'b00;
      end
    endcase
    // Software reset clears the counters regardless of the packet in flight.
    if (sw_rst) begin
      w_pkt_cnt0_nxt  = 32'd0;
      w_pkt_cnt1_nxt  = 32'd0;
      w_burst_cnt_nxt = {BCW{1'b0}};
    end else begin
      w_burst_cnt_nxt = w_burst_cnt_nxt;
    end
  end

  // State and counter registers; reset drops ownership immediately.
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      r_state      <= ST_IDLE;
      r_grant      <= 2'b00;
      r_last_owner <= 1'b1;
      r_has_hist   <= 1'b0;
      r_burst_cnt  <= {BCW{1'b0}};
      r_pkt_cnt0   <= 32'd0;
      r_pkt_cnt1   <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_has_hist   <= w_has_hist_nxt;
      r_burst_cnt  <= w_burst_cnt_nxt;
      r_pkt_cnt0   <= w_pkt_cnt0_nxt;
      r_pkt_cnt1   <= w_pkt_cnt1_nxt;
    end
  end

  assign grant    = r_grant;
  assign pkt_cnt0 = r_pkt_cnt0;
  assign pkt_cnt1 = r_pkt_cnt1;

endmodule

// File: tb/tb_osnt_ipd_arbiter.sv
// Testbench for osnt_ipd_arbiter: two queue-fed sources, an egress monitor
// that pops a scoreboard of expected beats, and one task per scenario.
module tb_osnt_ipd_arbiter;

  localparam int DW = 512;
  localparam int TW = 128;
  localparam int BW = 8;

  logic            clk;
  logic            axis_areset;
  logic [DW-1:0]   s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
  logic [DW/8-1:0] s0_axis_tkeep, s1_axis_tkeep, m_axis_tkeep;
  logic [TW-1:0]   s0_axis_tuser, s1_axis_tuser, m_axis_tuser;
  logic            s0_axis_tvalid, s0_axis_tlast, s0_axis_tready;
  logic            s1_axis_tvalid, s1_axis_tlast, s1_axis_tready;
  logic            m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic            sw_rst, arb_en;
  logic [BW-1:0]   burst_limit0, burst_limit1;
  logic [31:0]     pkt_cnt0, pkt_cnt1;
  logic [1:0]      grant;

  typedef struct packed {
    logic [31:0] tag;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic        src;
    logic [31:0] tag;
    logic        last;
  } exp_t;

  beat_t src0_q[$];
  beat_t src1_q[$];
  exp_t  exp_q[$];

  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_cnt0 = 32'd0;
  logic [31:0] m_cnt1 = 32'd0;
  bit          chk_after_last = 1'b0;
  bit          hs0, hs1;
  exp_t        mon_e;

  osnt_ipd_arbiter #(
    .C_AXIS_DATA_WIDTH (DW),
    .C_AXIS_TUSER_WIDTH(TW),
    .C_BURST_WIDTH     (BW)
  ) dut (
    .axis_aclk     (clk),
    .axis_areset   (axis_areset),
    .s0_axis_tdata (s0_axis_tdata),
    .s0_axis_tkeep (s0_axis_tkeep),
    .s0_axis_tuser (s0_axis_tuser),
    .s0_axis_tvalid(s0_axis_tvalid),
    .s0_axis_tlast (s0_axis_tlast),
    .s0_axis_tready(s0_axis_tready),
    .s1_axis_tdata (s1_axis_tdata),
    .s1_axis_tkeep (s1_axis_tkeep),
    .s1_axis_tuser (s1_axis_tuser),
    .s1_axis_tvalid(s1_axis_tvalid),
    .s1_axis_tlast (s1_axis_tlast),
    .s1_axis_tready(s1_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .sw_rst        (sw_rst),
    .arb_en        (arb_en),
    .burst_limit0  (burst_limit0),
    .burst_limit1  (burst_limit1),
    .pkt_cnt0      (pkt_cnt0),
    .pkt_cnt1      (pkt_cnt1),
    .grant         (grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Queue nb beats of one packet on a source and/or the expected list.
  task automatic add_pkt(input bit src, input int pid, input int nb, input bit to_src, input bit to_exp);
    for (int b = 0; b < nb; b++) begin
      beat_t bt;
      exp_t  ex;
      bt.tag  = {7'h50, src, pid[7:0], b[7:0], 8'h5C};
      bt.last = (b == nb - 1);
      ex.src  = src;
      ex.tag  = bt.tag;
      ex.last = bt.last;
      if (to_src) begin
        if (src) src1_q.push_back(bt);
        else     src0_q.push_back(bt);
      end
      if (to_exp) exp_q.push_back(ex);
    end
  endtask

  // Source 0 driver: advance on an accepted beat, present the queue head.
  initial begin
    forever begin
      @(negedge clk);
      hs0 = s0_axis_tvalid & s0_axis_tready;
      @(posedge clk);
      #1;
      if (hs0 && src0_q.size() > 0) void'(src0_q.pop_front());
      if (src0_q.size() > 0) begin
        s0_axis_tvalid = 1'b1;
        s0_axis_tdata  = {16{src0_q[0].tag}};
        s0_axis_tkeep  = {2{src0_q[0].tag}};
        s0_axis_tuser  = {4{src0_q[0].tag}};
        s0_axis_tlast  = src0_q[0].last;
      end else begin
        s0_axis_tvalid = 1'b0;
        s0_axis_tdata  = '0;
        s0_axis_tkeep  = '0;
        s0_axis_tuser  = '0;
        s0_axis_tlast  = 1'b0;
      end
    end
  end

  // Source 1 driver.
  initial begin
    forever begin
      @(negedge clk);
      hs1 = s1_axis_tvalid & s1_axis_tready;
      @(posedge clk);
      #1;
      if (hs1 && src1_q.size() > 0) void'(src1_q.pop_front());
      if (src1_q.size() > 0) begin
        s1_axis_tvalid = 1'b1;
        s1_axis_tdata  = {16{src1_q[0].tag}};
        s1_axis_tkeep  = {2{src1_q[0].tag}};
        s1_axis_tuser  = {4{src1_q[0].tag}};
        s1_axis_tlast  = src1_q[0].last;
      end else begin
        s1_axis_tvalid = 1'b0;
        s1_axis_tdata  = '0;
        s1_axis_tkeep  = '0;
        s1_axis_tuser  = '0;
        s1_axis_tlast  = 1'b0;
      end
    end
  end

  // Egress monitor: compare each accepted beat with the scoreboard, then
  // check the bubble and packet counters on the cycle after every tlast.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_after_last) begin
        chk_after_last = 1'b0;
        checks++;
        if (m_axis_tvalid !== 1'b0 || grant !== 2'b00) begin
          errors++;
          $display("FAIL bubble: tvalid=%b grant=%b, required tvalid=0 grant=00", m_axis_tvalid, grant);
        end
        checks++;
        if (pkt_cnt0 !== m_cnt0 || pkt_cnt1 !== m_cnt1) begin
          errors++;
          $display("FAIL pkt_cnt: got %h/%h, required %h/%h", pkt_cnt0, pkt_cnt1, m_cnt0, m_cnt1);
        end
      end
      if (!axis_areset && m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got tag %h grant=%b, required no beat", m_axis_tdata[31:0], grant);
        end else begin
          mon_e = exp_q.pop_front();
          if (m_axis_tdata !== {16{mon_e.tag}} || m_axis_tkeep !== {2{mon_e.tag}} ||
              m_axis_tuser !== {4{mon_e.tag}} || m_axis_tlast !== mon_e.last ||
              grant !== (mon_e.src ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL beat: got tag %h last=%b grant=%b, required tag %h last=%b src=%0d",
                     m_axis_tdata[31:0], m_axis_tlast, grant, mon_e.tag, mon_e.last, mon_e.src);
          end
          if (mon_e.last) begin
            if (mon_e.src) m_cnt1 = m_cnt1 + 32'd1;
            else           m_cnt0 = m_cnt0 + 32'd1;
            chk_after_last = 1'b1;
          end
        end
      end
    end
  end

  // Wait (bounded) for the scoreboard to drain, then settle a few cycles.
  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d beats outstanding, required 0", nm, exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Bounded wait for the egress to start passing a beat.
  task automatic wait_tvalid(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!m_axis_tvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!m_axis_tvalid) begin
      errors++;
      $display("FAIL %s_start: m_axis_tvalid=0, required 1", nm);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b, required 00", grant); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b, required 0", m_axis_tvalid); end
    checks++; if (s0_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_s0_tready: got %b, required 0", s0_axis_tready); end
    checks++; if (s1_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_s1_tready: got %b, required 0", s1_axis_tready); end
    checks++; if (pkt_cnt0 !== 32'd0) begin errors++; $display("FAIL rst_pkt_cnt0: got %h, required 0", pkt_cnt0); end
    checks++; if (pkt_cnt1 !== 32'd0) begin errors++; $display("FAIL rst_pkt_cnt1: got %h, required 0", pkt_cnt1); end
    @(posedge clk);
    #1;
    axis_areset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Both inputs always valid, limits 2/1 -> order 0,0,1,0,0,1.
  task automatic test_round_robin();
    burst_limit0 = 8'd2;
    burst_limit1 = 8'd1;
    for (int p = 0; p < 4; p++) add_pkt(1'b0, p, 3, 1'b1, 1'b0);
    for (int p = 0; p < 2; p++) add_pkt(1'b1, p, 3, 1'b1, 1'b0);
    add_pkt(1'b0, 0, 3, 1'b0, 1'b1);
    add_pkt(1'b0, 1, 3, 1'b0, 1'b1);
    add_pkt(1'b1, 0, 3, 1'b0, 1'b1);
    add_pkt(1'b0, 2, 3, 1'b0, 1'b1);
    add_pkt(1'b0, 3, 3, 1'b0, 1'b1);
    add_pkt(1'b1, 1, 3, 1'b0, 1'b1);
    wait_done("rr");
    checks++; if (pkt_cnt0 !== 32'd4) begin errors++; $display("FAIL rr_pkt_cnt0: got %0d, required 4", pkt_cnt0); end
    checks++; if (pkt_cnt1 !== 32'd2) begin errors++; $display("FAIL rr_pkt_cnt1: got %0d, required 2", pkt_cnt1); end
  endtask

  task automatic test_sw_rst();
    sw_rst = 1'b1;
    @(posedge clk);
    #1;
    sw_rst = 1'b0;
    m_cnt0 = 32'd0;
    m_cnt1 = 32'd0;
    @(negedge clk);
    checks++; if (pkt_cnt0 !== 32'd0) begin errors++; $display("FAIL swrst_pkt_cnt0: got %0d, required 0", pkt_cnt0); end
    checks++; if (pkt_cnt1 !== 32'd0) begin errors++; $display("FAIL swrst_pkt_cnt1: got %0d, required 0", pkt_cnt1); end
    @(posedge clk);
    #1;
  endtask

  // Limit 0 acts as 1: input 0 alone keeps winning, one bubble per packet.
  task automatic test_burst_zero();
    burst_limit0 = 8'd0;
    for (int p = 10; p < 13; p++) add_pkt(1'b0, p, 2, 1'b1, 1'b1);
    wait_done("bz");
    checks++; if (pkt_cnt0 !== 32'd3) begin errors++; $display("FAIL bz_pkt_cnt0: got %0d, required 3", pkt_cnt0); end
  endtask

  // m_axis_tready toggling: s0 tready follows it, s1 stays closed.
  task automatic test_backpressure();
    int n;
    n = 0;
    add_pkt(1'b0, 15, 4, 1'b1, 1'b1);
    while (exp_q.size() > 0 && n < 60) begin
      @(posedge clk);
      #1;
      m_axis_tready = ~m_axis_tready;
      @(negedge clk);
      if (grant == 2'b01) begin
        checks++;
        if (s0_axis_tready !== m_axis_tready || s1_axis_tready !== 1'b0) begin
          errors++;
          $display("FAIL bp_tready: got s0=%b s1=%b, required s0=%b s1=0", s0_axis_tready, s1_axis_tready, m_axis_tready);
        end
      end
      n++;
    end
    @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    wait_done("bp");
  endtask

  // arb_en dropped mid-packet: packet completes, then no new grant.
  task automatic test_arb_en();
    add_pkt(1'b0, 20, 3, 1'b1, 1'b1);
    wait_tvalid("arb");
    @(posedge clk);
    #1;
    arb_en = 1'b0;
    add_pkt(1'b1, 21, 2, 1'b1, 1'b0);
    wait_done("arb");
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (m_axis_tvalid !== 1'b0 || s1_axis_tready !== 1'b0 || grant !== 2'b00) begin
        errors++;
        $display("FAIL arb_hold: got tvalid=%b s1_tready=%b grant=%b, required 0/0/00", m_axis_tvalid, s1_axis_tready, grant);
      end
    end
    @(posedge clk);
    #1;
    add_pkt(1'b1, 21, 2, 1'b0, 1'b1);
    arb_en = 1'b1;
    wait_done("arb_resume");
  endtask

  // pkt_cnt0 preloaded to all-ones wraps to zero on the next packet.
  task automatic test_wrap();
    force dut.r_pkt_cnt0 = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    release dut.r_pkt_cnt0;
    m_cnt0 = 32'hFFFF_FFFF;
    add_pkt(1'b0, 30, 2, 1'b1, 1'b1);
    wait_done("wrap");
    checks++; if (pkt_cnt0 !== 32'd0) begin errors++; $display("FAIL wrap_pkt_cnt0: got %h, required 00000000", pkt_cnt0); end
  endtask

  // Asynchronous reset mid-packet drops ownership within the cycle.
  task automatic test_async_reset();
    add_pkt(1'b1, 35, 4, 1'b1, 1'b1);
    wait_tvalid("ares");
    @(posedge clk);
    #2;
    axis_areset = 1'b1;
    src0_q.delete();
    src1_q.delete();
    exp_q.delete();
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL ares_grant: got %b, required 00", grant); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL ares_tvalid: got %b, required 0", m_axis_tvalid); end
    checks++; if (s1_axis_tready !== 1'b0) begin errors++; $display("FAIL ares_s1_tready: got %b, required 0", s1_axis_tready); end
    checks++; if (pkt_cnt0 !== 32'd0 || pkt_cnt1 !== 32'd0) begin errors++; $display("FAIL ares_cnt: got %h/%h, required 0/0", pkt_cnt0, pkt_cnt1); end
    repeat (2) @(posedge clk);
    #1;
    axis_areset = 1'b0;
    m_cnt0 = 32'd0;
    m_cnt1 = 32'd0;
    burst_limit0 = 8'd1;
    burst_limit1 = 8'd1;
    add_pkt(1'b0, 40, 2, 1'b1, 1'b0);
    add_pkt(1'b1, 41, 2, 1'b1, 1'b0);
    add_pkt(1'b0, 40, 2, 1'b0, 1'b1);
    add_pkt(1'b1, 41, 2, 1'b0, 1'b1);
    wait_done("ares_after");
  endtask

  initial begin
    axis_areset    = 1'b1;
    sw_rst         = 1'b0;
    arb_en         = 1'b1;
    burst_limit0   = 8'd1;
    burst_limit1   = 8'd1;
    m_axis_tready  = 1'b1;
    s0_axis_tvalid = 1'b0;
    s0_axis_tdata  = '0;
    s0_axis_tkeep  = '0;
    s0_axis_tuser  = '0;
    s0_axis_tlast  = 1'b0;
    s1_axis_tvalid = 1'b0;
    s1_axis_tdata  = '0;
    s1_axis_tkeep  = '0;
    s1_axis_tuser  = '0;
    s1_axis_tlast  = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_round_robin();
    test_sw_rst();
    test_burst_zero();
    test_backpressure();
    test_arb_en();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
